// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch stage and its neighbours.
package cpu_pkg;

  typedef logic [31:0] word_t;

  // Fetch sequencer states.
  // S_KILL waits out a response that a redirect has already made stale.
  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_KILL,
    S_HOLD
  } fetch_state_t;

  localparam word_t NOP_DEFAULT      = 32'h0000_0000;
  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle: one outstanding fetch at a time.
interface if_stage_if;
  import cpu_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_rvalid;
  word_t imem_rdata;

  // Fetch unit side.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Memory side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/pc_next_mux.sv
// Redirect detection, redirect target selection and sequential PC+4.
module pc_next_mux
  import cpu_pkg::*;
(
  input  word_t pc_i,
  input  logic  jump_reg_i,
  input  word_t pcjreg_i,
  input  logic  jump_i,
  input  word_t pcjump_i,
  input  logic  pcsrc_i,
  input  word_t pcbranch_i,
  output logic  redirect_o,
  output word_t target_o,
  output word_t pc_plus4_o
);

  // Register jumps win over jumps, which win over taken branches.
  always_comb begin
    redirect_o = jump_reg_i | jump_i | pcsrc_i;
    if (jump_reg_i) begin
      target_o = pcjreg_i;
    end else if (jump_i) begin
      target_o = pcjump_i;
    end else begin
      target_o = pcbranch_i;
    end
    // Plain 32-bit add: the top of the address space wraps to zero.
    pc_plus4_o = pc_i + 32'd4;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, sequences single-outstanding fetches,
// applies stalls and redirects, and drives the IF/ID pipeline register.
module if_stage
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEFAULT,
  parameter word_t NOP      = NOP_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_F,
  input  logic            stall_D,
  input  logic            flushD,
  input  logic            pcsrcD,
  input  word_t           pcbranchD,
  input  logic            jumpD,
  input  word_t           pcjumpD,
  input  logic            jump_reg,
  input  word_t           pcjregD,
  if_stage_if.master      imem,
  output word_t           instrD,
  output word_t           pcplus4D,
  output logic            validD
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        instr_q, instr_d;
  word_t        pc4_q, pc4_d;
  logic         valid_q, valid_d;
  word_t        hold_instr_q, hold_instr_d;
  word_t        hold_pc4_q, hold_pc4_d;

  logic  redirect;
  word_t target;
  word_t pc_plus4;

  logic  req;
  word_t addr;
  logic  accept;
  logic  deliver;
  word_t dlv_instr;
  word_t dlv_pc4;

  pc_next_mux u_pc_next_mux (
    .pc_i       (pc_q),
    .jump_reg_i (jump_reg),
    .pcjreg_i   (pcjregD),
    .jump_i     (jumpD),
    .pcjump_i   (pcjumpD),
    .pcsrc_i    (pcsrcD),
    .pcbranch_i (pcbranchD),
    .redirect_o (redirect),
    .target_o   (target),
    .pc_plus4_o (pc_plus4)
  );

  // Decode can take an instruction this cycle only if it is neither stalled nor
  // being flushed; otherwise a returning word is parked in the hold buffer.
  assign accept = ~stall_D & ~flushD;

  // Fetch sequencer, instruction hand-off and IF/ID next-state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    req          = 1'b0;
    addr         = pc_q;
    deliver      = 1'b0;
    dlv_instr    = imem.imem_rdata;
    dlv_pc4      = pc_plus4;

    unique case (state_q)
      S_REQ: begin
        // A response arriving here belongs to a pre-reset fetch and is ignored.
        if (redirect) begin
          pc_d = target;
        end else if (!stall_F) begin
          req     = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!imem.imem_rvalid) begin
          if (redirect) begin
            pc_d    = target;
            state_d = S_KILL;
          end
        end else if (redirect) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (accept) begin
          deliver = 1'b1;
          pc_d    = pc_plus4;
          // Back-to-back issue keeps one instruction per cycle with k=1 memory.
          if (!stall_F) begin
            req  = 1'b1;
            addr = pc_plus4;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          hold_instr_d = imem.imem_rdata;
          hold_pc4_d   = pc_plus4;
          state_d      = S_HOLD;
        end
      end

      S_KILL: begin
        if (redirect) begin
          pc_d = target;
        end
        if (imem.imem_rvalid) begin
          state_d = S_REQ;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (accept) begin
          deliver   = 1'b1;
          dlv_instr = hold_instr_q;
          dlv_pc4   = hold_pc4_q;
          pc_d      = hold_pc4_q;
          state_d   = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase

    // Flush forces a bubble even while decode is stalled.
    if (flushD) begin
      instr_d = NOP;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (!stall_D) begin
      if (deliver) begin
        instr_d = dlv_instr;
        pc4_d   = dlv_pc4;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
      end
    end else begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end
  end

  // Request is suppressed during reset even if the old state would issue one.
  assign imem.imem_req  = req & ~reset;
  assign imem.imem_addr = addr;

  assign instrD   = instr_q;
  assign pcplus4D = pc4_q;
  assign validD   = valid_q;

  // State, PC, IF/ID and hold buffer with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      instr_q      <= NOP;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
      hold_instr_q <= NOP;
      hold_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table plus randomized traffic against a
// transaction-level model with a latency-randomized memory.
module tb_if_stage;
  import cpu_pkg::*;

  logic  clk = 1'b0;
  logic  reset, stall_F, stall_D, flushD;
  logic  pcsrcD, jumpD, jump_reg;
  word_t pcbranchD, pcjumpD, pcjregD;
  word_t instrD, pcplus4D;
  logic  validD;

  if_stage_if imem_bus ();

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP      (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall_F   (stall_F),
    .stall_D   (stall_D),
    .flushD    (flushD),
    .pcsrcD    (pcsrcD),
    .pcbranchD (pcbranchD),
    .jumpD     (jumpD),
    .pcjumpD   (pcjumpD),
    .jump_reg  (jump_reg),
    .pcjregD   (pcjregD),
    .imem      (imem_bus),
    .instrD    (instrD),
    .pcplus4D  (pcplus4D),
    .validD    (validD)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] ctl;   // {reset, stall_F, stall_D, flushD}
    logic [2:0] mask;  // {jump_reg, jumpD, pcsrcD}
    word_t      tgt;
    logic       rv;
    word_t      rd;
    logic       e_req;
    word_t      e_addr;
    word_t      e_instr;
    word_t      e_pc4;
    logic       e_val;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] ctl, input logic [2:0] mask, input word_t tgt,
                     input logic rv, input word_t rd, input logic e_req, input word_t e_addr,
                     input word_t e_instr, input word_t e_pc4, input logic e_val);
    vec_t v;
    v.ctl = ctl; v.mask = mask; v.tgt = tgt; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_val = e_val;
    tbl.push_back(v);
  endtask

  task automatic chk32(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Lower-priority redirect buses carry a decoy target so priority errors show.
  task automatic drive(input logic rst, input logic sf, input logic sd, input logic fl,
                       input logic [2:0] mask, input word_t tgt, input logic rv, input word_t rd);
    @(negedge clk);
    reset     = rst;
    stall_F   = sf;
    stall_D   = sd;
    flushD    = fl;
    jump_reg  = mask[2];
    jumpD     = mask[1];
    pcsrcD    = mask[0];
    pcjregD   = tgt;
    pcjumpD   = mask[2] ? tgt + 32'h100 : tgt;
    pcbranchD = (mask[2] | mask[1]) ? tgt + 32'h100 : tgt;
    imem_bus.imem_rvalid = rv;
    imem_bus.imem_rdata  = rd;
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_req, input word_t e_addr,
                         input word_t e_instr, input word_t e_pc4, input logic e_val);
    chk1({tag, ".imem_req"}, imem_bus.imem_req, e_req);
    if (e_req) chk32({tag, ".imem_addr"}, imem_bus.imem_addr, e_addr);
    chk32({tag, ".instrD"}, instrD, e_instr);
    chk32({tag, ".pcplus4D"}, pcplus4D, e_pc4);
    chk1({tag, ".validD"}, validD, e_val);
  endtask

  function automatic word_t mem_word(input word_t a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // Transaction-level reference state.
  word_t m_pc, m_buf_i, m_buf_p4, m_instr, m_pc4;
  logic  m_infl, m_dead, m_buf, m_val;

  // Memory responder state.
  logic  mem_pend;
  int    mem_cnt, mem_k;
  word_t mem_addr;

  task automatic model_reset();
    m_pc = 32'h0; m_infl = 1'b0; m_dead = 1'b0; m_buf = 1'b0;
    m_instr = 32'h0; m_pc4 = 32'h0; m_val = 1'b0;
  endtask

  initial begin
    word_t bub = 32'h0;
    reset = 1'b1; stall_F = 1'b0; stall_D = 1'b0; flushD = 1'b0;
    pcsrcD = 1'b0; jumpD = 1'b0; jump_reg = 1'b0;
    pcbranchD = 32'h0; pcjumpD = 32'h0; pcjregD = 32'h0;
    imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = 32'h0;

    // ctl={rst,sF,sD,fl}  mask={jr,j,br}  tgt  rv rd | req addr instrD pcplus4D validD
    add(4'b1000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,   bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b1, 32'h1111_0000, 1'b1, 32'h4,  bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b1, 32'h1111_0004, 1'b1, 32'h8,
        32'h1111_0000, 32'h4, 1'b1);
    add(4'b0000, 3'b010, 32'h100,      1'b0, 32'h0,        1'b0, 32'h0,
        32'h1111_0004, 32'h8, 1'b1);
    add(4'b0000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b1, 32'hBADB_AD00, 1'b0, 32'h0,  bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b1, 32'h100, bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   bub, 32'h0, 1'b0);
    add(4'b0010, 3'b000, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,  bub, 32'h0, 1'b0);
    add(4'b0010, 3'b000, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   bub, 32'h0, 1'b0);
    add(4'b0010, 3'b000, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b1, 32'h104,
        32'hDEAD_BEEF, 32'h104, 1'b1);
    add(4'b0000, 3'b101, 32'h200,      1'b1, 32'hBADB_AD01, 1'b0, 32'h0,  bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b1, 32'h200, bub, 32'h0, 1'b0);
    add(4'b0100, 3'b000, 32'h0,        1'b1, 32'h2222_0000, 1'b0, 32'h0,  bub, 32'h0, 1'b0);
    add(4'b0011, 3'b000, 32'h0,        1'b0, 32'h0,        1'b1, 32'h204,
        32'h2222_0000, 32'h204, 1'b1);
    add(4'b0000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   bub, 32'h0, 1'b0);
    add(4'b1000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   bub, 32'h0, 1'b0);
    add(4'b0100, 3'b000, 32'h0,        1'b1, 32'hBADB_AD02, 1'b0, 32'h0,  bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,   bub, 32'h0, 1'b0);
    add(4'b0000, 3'b010, 32'hFFFF_FFFC, 1'b0, 32'h0,       1'b0, 32'h0,   bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b1, 32'hBADB_AD03, 1'b0, 32'h0,  bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b1, 32'h4444_0000, 1'b1, 32'h0,  bub, 32'h0, 1'b0);
    add(4'b0001, 3'b000, 32'h0,        1'b1, 32'h5555_0000, 1'b0, 32'h0,
        32'h4444_0000, 32'h0, 1'b1);
    add(4'b0000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b1, 32'h4,
        32'h5555_0000, 32'h4, 1'b1);
    add(4'b0000, 3'b001, 32'h40,       1'b1, 32'hBADB_AD04, 1'b0, 32'h0,  bub, 32'h0, 1'b0);
    add(4'b0000, 3'b000, 32'h0,        1'b0, 32'h0,        1'b1, 32'h40,  bub, 32'h0, 1'b0);

    // Two unchecked reset cycles so IF/ID starts from known values.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      drive(v.ctl[3], v.ctl[2], v.ctl[1], v.ctl[0], v.mask, v.tgt, v.rv, v.rd);
      chk_all($sformatf("vec%0d", i), v.e_req, v.e_addr, v.e_instr, v.e_pc4, v.e_val);
    end

    // Randomized traffic.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0);
    model_reset();
    mem_pend = 1'b0; mem_cnt = 0; mem_k = 1; mem_addr = 32'h0;

    for (int c = 0; c < 3000; c++) begin
      logic       rst, sf, sd, fl, rv, redir, ok, e_req, dl;
      logic [2:0] mask;
      word_t      tgt, rd, e_addr, npc, di, dp, raw;
      rst  = ($urandom_range(0, 99) < 2);
      sf   = ($urandom_range(0, 3) == 0);
      sd   = ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 9) == 0);
      mask = {($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 11) == 0)};
      raw  = $urandom;
      tgt  = raw & 32'hFFFF_FFFC;
      rd   = $urandom;
      rv   = 1'b0;
      if (mem_pend) begin
        mem_cnt++;
        if (mem_cnt >= mem_k) begin
          rv = 1'b1;
          rd = mem_word(mem_addr);
        end
      end
      drive(rst, sf, sd, fl, mask, tgt, rv, rd);

      redir = |mask;
      ok    = !sd && !fl;
      e_req = 1'b0; e_addr = 32'h0; dl = 1'b0; di = 32'h0; dp = 32'h0;
      npc   = m_pc;
      if (rst) begin
        e_req = 1'b0;
      end else if (m_buf) begin
        if (redir) begin
          m_buf = 1'b0; npc = tgt;
        end else if (ok) begin
          dl = 1'b1; di = m_buf_i; dp = m_buf_p4; npc = m_buf_p4; m_buf = 1'b0;
        end
      end else if (m_infl) begin
        if (rv) begin
          m_infl = 1'b0;
          if (m_dead || redir) begin
            if (redir) npc = tgt;
          end else if (ok) begin
            dl = 1'b1; di = rd; dp = m_pc + 32'd4; npc = m_pc + 32'd4;
            if (!sf) begin
              e_req = 1'b1; e_addr = npc; m_infl = 1'b1; m_dead = 1'b0;
            end
          end else begin
            m_buf = 1'b1; m_buf_i = rd; m_buf_p4 = m_pc + 32'd4;
          end
        end else if (redir) begin
          npc = tgt; m_dead = 1'b1;
        end
      end else begin
        if (redir) begin
          npc = tgt;
        end else if (!sf) begin
          e_req = 1'b1; e_addr = m_pc; m_infl = 1'b1; m_dead = 1'b0;
        end
      end

      chk_all($sformatf("rnd%0d", c), e_req, e_addr, m_instr, m_pc4, m_val);

      m_pc = npc;
      if (rst) begin
        model_reset();
      end else if (fl || (!sd && !dl)) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_val = 1'b0;
      end else if (!sd) begin
        m_instr = di; m_pc4 = dp; m_val = 1'b1;
      end

      if (rv) mem_pend = 1'b0;
      if (imem_bus.imem_req && !rst) begin
        mem_pend = 1'b1; mem_cnt = 0; mem_k = $urandom_range(1, 3);
        mem_addr = imem_bus.imem_addr;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
